// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int         NUM_REQ_DEF  = 4;
  localparam int         WIDTH_DEF    = 4;
  localparam logic [7:0] WR_COUNT_MAX = 8'd255;

endpackage

// File: rtl/register_nbit.sv
// WIDTH-bit storage register: load enable, synchronous clear wins over load.
// Latency: one clock from ld to q; no flow control.
module register_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (ld) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time a write into a shared register.
// Latency: gnt one cycle after req, q/ack two cycles after; requesters hold req until ack (IDLE->LOAD->ACK).
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [7:0]               wr_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [NUM_REQ-1:0] ack_q,   ack_d;
  logic [7:0]         cnt_q,   cnt_d;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               reg_ld;
  logic [WIDTH-1:0]   reg_d;

  // Scan from the farthest candidate back to ptr so the nearest asserted request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    ack_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          owner_d        = win_idx;
          gnt_d[win_idx] = 1'b1;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ack_d[owner_q] = 1'b1;
        cnt_d          = (cnt_q == WR_COUNT_MAX) ? cnt_q : cnt_q + 8'd1;
        state_d        = ST_ACK;
      end
      ST_ACK: begin
        ptr_d   = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data is taken from the owner's slice during LOAD only, so later wdata changes cannot leak in.
  assign reg_ld = (state_q == ST_LOAD);
  assign reg_d  = wdata[int'(owner_q)*WIDTH +: WIDTH];

  register_nbit #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk (clk),
    .clr (rst),
    .ld  (reg_ld),
    .d   (reg_d),
    .q   (q)
  );

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign busy     = (state_q != ST_IDLE);
  assign wr_count = cnt_q;

endmodule
